// File: rtl/ym6045c_z80_bank_bridge_if.sv
// Z80 and 68k bus pins of the YM6045C bank-window bridge, plus bank/bus_err status.
// The bridge takes the master view because it drives the 68k bus on the Z80's behalf.
interface ym6045c_z80_bank_bridge_if;
  logic        z80_mreq_n;
  logic        z80_rd_n;
  logic        z80_wr_n;
  logic [15:0] z80_a;
  logic [7:0]  z80_d_in;
  logic [7:0]  z80_d_out;
  logic        z80_wait_n;
  logic        m68k_br_n;
  logic        m68k_bg_n;
  logic [22:0] m68k_a;
  logic        m68k_as_n;
  logic        m68k_uds_n;
  logic        m68k_lds_n;
  logic        m68k_rw;
  logic [15:0] m68k_d_in;
  logic [15:0] m68k_d_out;
  logic        m68k_dtack_n;
  logic        bus_err;
  logic [8:0]  bank;

  modport master (
    input  z80_mreq_n, z80_rd_n, z80_wr_n, z80_a, z80_d_in,
    input  m68k_bg_n, m68k_d_in, m68k_dtack_n,
    output z80_d_out, z80_wait_n,
    output m68k_br_n, m68k_a, m68k_as_n, m68k_uds_n, m68k_lds_n, m68k_rw, m68k_d_out,
    output bus_err, bank
  );

  modport slave (
    output z80_mreq_n, z80_rd_n, z80_wr_n, z80_a, z80_d_in,
    output m68k_bg_n, m68k_d_in, m68k_dtack_n,
    input  z80_d_out, z80_wait_n,
    input  m68k_br_n, m68k_a, m68k_as_n, m68k_uds_n, m68k_lds_n, m68k_rw, m68k_d_out,
    input  bus_err, bank
  );
endinterface

// File: rtl/ym6045c_z80_bank_bridge.sv
// Z80-to-68k bank window bridge: a Z80 access to 0x8000-0xFFFF becomes one 68k byte cycle
// at {bank, A14..A0}; writes to the bank page shift Z80 D0 into the 9-bit bank register.
module ym6045c_z80_bank_bridge #(
  parameter int unsigned DTACK_TIMEOUT = 255,
  parameter logic [7:0]  BANK_PAGE     = 8'h60
) (
  input logic                       clk,
  input logic                       reset,
  ym6045c_z80_bank_bridge_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ADDR,
    STROBE,
    LATCH,
    RELEASE
  } state_t;

  state_t     state, state_d;
  logic [7:0] cnt;
  logic       wr_n_q;
  logic       a0_q;
  logic       access_req;
  logic       bank_wr;
  logic       dtack_seen;
  logic       timed_out;

  assign access_req = !bus.z80_mreq_n && bus.z80_a[15] && (!bus.z80_rd_n || !bus.z80_wr_n);
  assign bank_wr    = wr_n_q && !bus.z80_wr_n && !bus.z80_mreq_n && (bus.z80_a[15:8] == BANK_PAGE);
  assign dtack_seen = !bus.m68k_dtack_n;
  // DTACK arriving in the final allowed cycle still counts as a normal completion.
  assign timed_out  = !dtack_seen && (cnt == 8'(DTACK_TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state;
    case (state)
      IDLE:    if (access_req)          state_d = REQ;
      REQ:     if (!bus.m68k_bg_n)      state_d = ADDR;
      ADDR:                             state_d = STROBE;
      STROBE:  if (dtack_seen || timed_out) state_d = LATCH;
      LATCH:                            state_d = RELEASE;
      RELEASE: if (bus.z80_mreq_n)      state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // NOTE: clocked blocks use non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.m68k_br_n  <= 1'b1;
      bus.z80_wait_n <= 1'b1;
      bus.m68k_as_n  <= 1'b1;
      bus.m68k_uds_n <= 1'b1;
      bus.m68k_lds_n <= 1'b1;
      bus.m68k_rw    <= 1'b1;
      bus.m68k_a     <= '0;
      bus.m68k_d_out <= '0;
      bus.z80_d_out  <= 8'hFF;
      bus.bus_err    <= 1'b0;
      bus.bank       <= '0;
      cnt            <= '0;
      wr_n_q         <= 1'b1;
      a0_q           <= 1'b0;
    end else begin
      wr_n_q      <= bus.z80_wr_n;
      bus.bus_err <= 1'b0;

      if (bank_wr) bus.bank <= {bus.z80_d_in[0], bus.bank[8:1]};

      // The Z80 stays stalled and the 68k bus stays requested from REQ through LATCH.
      bus.m68k_br_n  <= (state_d == IDLE) || (state_d == RELEASE);
      bus.z80_wait_n <= (state_d == IDLE) || (state_d == RELEASE);

      case (state)
        ADDR: begin
          bus.m68k_a     <= {bus.bank, bus.z80_a[14:1]};
          bus.m68k_rw    <= !bus.z80_rd_n;
          a0_q           <= bus.z80_a[0];
          if (bus.z80_rd_n) bus.m68k_d_out <= {bus.z80_d_in, bus.z80_d_in};
          bus.m68k_as_n  <= 1'b0;
          bus.m68k_uds_n <= bus.z80_a[0];
          bus.m68k_lds_n <= !bus.z80_a[0];
          cnt            <= 8'd1;
        end
        STROBE: begin
          if (dtack_seen || timed_out) begin
            bus.m68k_as_n  <= 1'b1;
            bus.m68k_uds_n <= 1'b1;
            bus.m68k_lds_n <= 1'b1;
            bus.bus_err    <= timed_out;
            if (bus.m68k_rw)
              bus.z80_d_out <= timed_out ? 8'hFF
                             : (a0_q ? bus.m68k_d_in[7:0] : bus.m68k_d_in[15:8]);
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
